// File: rtl/product_accumulator.sv
// Sums BLOCK_LEN consecutive valid multiplier products into one result and
// strobes it out with an incrementing address. Optional: PRODUCT_ACCUMULATOR_SATURATE_EN.
module product_accumulator #(
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 40,
    parameter int BLOCK_LEN = 4,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mul_in,
    input  logic              mul_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic              done,
    output logic              overflow
);

    localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_out_q, acc_out_d;
    logic              acc_valid_q, acc_valid_d;
    logic [ADDR_W-1:0] res_addr_q, res_addr_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic [ACC_W:0]    sum_s;
    logic [ACC_W-1:0]  next_acc_s;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    logic              sat_q, sat_d;
`endif

    // Next-state, accumulation and result sequencing
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = 1'b0;
        res_addr_d  = res_addr_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
        sum_s       = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, mul_in};
        next_acc_s  = sum_s[ACC_W-1:0];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        sat_d       = sat_q;
        // Once clamped, the block stays pinned at full scale until it closes
        if (sat_q || sum_s[ACC_W]) begin
            next_acc_s = '1;
        end else begin
            next_acc_s = sum_s[ACC_W-1:0];
        end
`endif

        // The address advances after each pulse, except after the final one
        if (acc_valid_q && !done_q) begin
            res_addr_d = res_addr_q + ADDR_W'(1);
        end else begin
            res_addr_d = res_addr_q;
        end

        case (state_q)
            IDLE, ACCUM: begin
                if (mul_valid) begin
                    if (sum_s[ACC_W]) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
                    if (cnt_q == CNT_LAST) begin
                        acc_out_d   = next_acc_s;
                        acc_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
                        sat_d       = 1'b0;
`endif
                        if (res_addr_d == {ADDR_W{1'b1}}) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        acc_d   = next_acc_s;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ACCUM;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
                        sat_d   = sat_q | sum_s[ACC_W];
`endif
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            res_addr_q  <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            res_addr_q  <= res_addr_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
    assign res_we    = acc_valid_q;
    assign res_addr  = res_addr_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule
